// File: rtl/joystick_gesture_decoder.sv
// rtl/joystick_gesture_decoder.sv - debounced joystick/button gesture tokens
// over a single-entry valid/ready output.

module joystick_gesture_axis #(
  parameter int       HI_TH       = 768,
  parameter int       LO_TH       = 256,
  parameter int       NEU_HI      = 640,
  parameter int       NEU_LO      = 384,
  parameter int       HOLD_CYCLES = 500000,
  parameter int       CNT_W       = 20,
  parameter logic [2:0] CODE_HI   = 3'd2,
  parameter logic [2:0] CODE_LO   = 3'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] v,
  output logic       emit,
  output logic [2:0] emit_code,
  output logic       neutral
);
  typedef enum logic [1:0] {NEUTRAL, QUAL, ACTIVE, RELEASE} state_t;

  localparam logic [9:0]       HI_V   = 10'(HI_TH);
  localparam logic [9:0]       LO_V   = 10'(LO_TH);
  localparam logic [9:0]       NHI_V  = 10'(NEU_HI);
  localparam logic [9:0]       NLO_V  = 10'(NEU_LO);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             side, side_d;
  logic             emit_q, emit_d;
  logic             beyond_hi, beyond_lo, beyond, in_band;

  assign beyond_hi = (v >= HI_V);
  assign beyond_lo = (v <= LO_V);
  assign beyond    = side ? beyond_hi : beyond_lo;
  assign in_band   = (v >= NLO_V) && (v <= NHI_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RELEASE;
      cnt    <= '0;
      side   <= 1'b0;
      emit_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      side   <= side_d;
      emit_q <= emit_d;
    end
  end

  // The counter value is tested before incrementing, so the transition lands on
  // the edge that consumes the HOLD_CYCLES-th qualifying sample.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    side_d  = side;
    emit_d  = 1'b0;
    case (state)
      NEUTRAL: begin
        if (beyond_hi || beyond_lo) begin
          side_d  = beyond_hi;
          cnt_d   = ONE;
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (!beyond) begin
          cnt_d   = '0;
          state_d = NEUTRAL;
        end else if (cnt >= LAST) begin
          cnt_d   = '0;
          emit_d  = 1'b1;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      ACTIVE: begin
        if (in_band) begin
          cnt_d   = ONE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!in_band) begin
          cnt_d = '0;
        end else if (cnt >= LAST) begin
          cnt_d   = '0;
          state_d = NEUTRAL;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      default: state_d = RELEASE;
    endcase
  end

  always_comb begin
    emit      = emit_q;
    emit_code = side ? CODE_HI : CODE_LO;
    neutral   = (state == NEUTRAL);
  end
endmodule

module joystick_gesture_decoder #(
  parameter int HI_TH       = 768,
  parameter int LO_TH       = 256,
  parameter int NEU_HI      = 640,
  parameter int NEU_LO      = 384,
  parameter int HOLD_CYCLES = 500000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       btn,
  output logic       gest_valid,
  output logic [2:0] gest_code,
  input  logic       gest_ready,
  output logic       gest_drop,
  output logic       stick_neutral
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [9:0]       x_q, y_q;
  logic             btn_q, btn_db, btn_emit;
  logic [CNT_W-1:0] btn_cnt;
  logic             x_emit, y_emit, x_neutral, y_neutral;
  logic [2:0]       x_code, y_code, win_code;
  logic             any_emit, multi_emit, can_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= 10'd512;
      y_q   <= 10'd512;
      btn_q <= 1'b0;
    end else begin
      x_q   <= x_pos;
      y_q   <= y_pos;
      btn_q <= btn;
    end
  end

  joystick_gesture_axis #(
    .HI_TH(HI_TH), .LO_TH(LO_TH), .NEU_HI(NEU_HI), .NEU_LO(NEU_LO),
    .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W), .CODE_HI(3'd2), .CODE_LO(3'd1)
  ) u_x (
    .clk(clk), .reset(reset), .v(x_q),
    .emit(x_emit), .emit_code(x_code), .neutral(x_neutral)
  );

  joystick_gesture_axis #(
    .HI_TH(HI_TH), .LO_TH(LO_TH), .NEU_HI(NEU_HI), .NEU_LO(NEU_LO),
    .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W), .CODE_HI(3'd3), .CODE_LO(3'd4)
  ) u_y (
    .clk(clk), .reset(reset), .v(y_q),
    .emit(y_emit), .emit_code(y_code), .neutral(y_neutral)
  );

  // Only a debounced rising edge produces a token; release is silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db   <= 1'b0;
      btn_cnt  <= '0;
      btn_emit <= 1'b0;
    end else begin
      btn_emit <= 1'b0;
      if (btn_q != btn_db) begin
        if (btn_cnt >= LAST) begin
          btn_db   <= btn_q;
          btn_cnt  <= '0;
          btn_emit <= btn_q;
        end else begin
          btn_cnt <= btn_cnt + ONE;
        end
      end else begin
        btn_cnt <= '0;
      end
    end
  end

  always_comb begin
    win_code = 3'd0;
    if (btn_emit)    win_code = 3'd5;
    else if (y_emit) win_code = y_code;
    else if (x_emit) win_code = x_code;
    any_emit   = btn_emit | y_emit | x_emit;
    multi_emit = (btn_emit & y_emit) | (btn_emit & x_emit) | (y_emit & x_emit);
    can_load   = !gest_valid || gest_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gest_valid    <= 1'b0;
      gest_code     <= 3'd0;
      gest_drop     <= 1'b0;
      stick_neutral <= 1'b0;
    end else begin
      gest_drop     <= any_emit && (!can_load || multi_emit);
      stick_neutral <= x_neutral & y_neutral;
      if (any_emit && can_load) begin
        gest_valid <= 1'b1;
        gest_code  <= win_code;
      end else if (gest_valid && gest_ready) begin
        gest_valid <= 1'b0;
        gest_code  <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_joystick_gesture_decoder.sv
// tb/tb_joystick_gesture_decoder.sv - directed self-checking bench for the
// gesture decoder with HOLD_CYCLES=4.

module tb_joystick_gesture_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pos, y_pos;
  logic       btn, gest_ready;
  logic       gest_valid, gest_drop, stick_neutral;
  logic [2:0] gest_code;

  int checks = 0;
  int failures = 0;
  int tok_cnt = 0;
  int t0;

  joystick_gesture_decoder #(
    .HI_TH(768), .LO_TH(256), .NEU_HI(640), .NEU_LO(384),
    .HOLD_CYCLES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
    .gest_valid(gest_valid), .gest_code(gest_code), .gest_ready(gest_ready),
    .gest_drop(gest_drop), .stick_neutral(stick_neutral)
  );

  always #5 clk = ~clk;

  // Accepted-token counter (handshakes seen on the clock edge).
  always @(posedge clk) begin
    if (!reset && gest_valid && gest_ready) tok_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; x_pos = 10'd0; y_pos = 10'd0; btn = 1'b0; gest_ready = 1'b1;
    step(3);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", gest_valid); end
    checks++; if (gest_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", gest_code); end
    checks++; if (gest_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0b exp=0", gest_drop); end
    checks++; if (stick_neutral !== 1'b0) begin failures++; $display("FAIL reset_neutral got=%0b exp=0", stick_neutral); end
    reset = 1'b0;
    step(20);
    checks++; if (tok_cnt !== 0 || gest_valid !== 1'b0) begin failures++; $display("FAIL powerup_deflect tokens=%0d valid=%0b exp=0/0", tok_cnt, gest_valid); end
  endtask

  task automatic test_right;
    x_pos = 10'd512; y_pos = 10'd512;
    step(8);
    checks++; if (stick_neutral !== 1'b1) begin failures++; $display("FAIL neutral_before got=%0b exp=1", stick_neutral); end
    t0 = tok_cnt;
    x_pos = 10'd900;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL right_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd2) begin failures++; $display("FAIL right_token valid=%0b code=%0d exp=1/2", gest_valid, gest_code); end
    step(1);
    checks++; if (gest_valid !== 1'b0 || tok_cnt !== t0 + 1) begin failures++; $display("FAIL right_accept valid=%0b tokens=%0d exp=0/%0d", gest_valid, tok_cnt, t0 + 1); end
    checks++; if (stick_neutral !== 1'b0) begin failures++; $display("FAIL neutral_after got=%0b exp=0", stick_neutral); end
  endtask

  task automatic test_hold_left;
    step(93);
    checks++; if (tok_cnt !== t0 + 1) begin failures++; $display("FAIL hold_no_repeat tokens=%0d exp=%0d", tok_cnt, t0 + 1); end
    x_pos = 10'd512;
    step(4);
    x_pos = 10'd100;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL left_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd1) begin failures++; $display("FAIL left_token valid=%0b code=%0d exp=1/1", gest_valid, gest_code); end
    step(1);
  endtask

  task automatic test_short_up;
    x_pos = 10'd512;
    step(6);
    t0 = tok_cnt;
    x_pos = 10'd900;
    step(3);
    x_pos = 10'd512;
    step(10);
    checks++; if (tok_cnt !== t0 || gest_valid !== 1'b0) begin failures++; $display("FAIL short_pulse tokens=%0d valid=%0b exp=%0d/0", tok_cnt, gest_valid, t0); end
    x_pos = 10'd767;
    step(10);
    checks++; if (tok_cnt !== t0) begin failures++; $display("FAIL below_hi_th tokens=%0d exp=%0d", tok_cnt, t0); end
    x_pos = 10'd512;
    step(2);
    y_pos = 10'd1000;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL up_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd3) begin failures++; $display("FAIL up_token valid=%0b code=%0d exp=1/3", gest_valid, gest_code); end
    step(1);
    y_pos = 10'd700;
    step(5);
    y_pos = 10'd1000;
    step(10);
    checks++; if (tok_cnt !== t0 + 1) begin failures++; $display("FAIL hysteresis tokens=%0d exp=%0d", tok_cnt, t0 + 1); end
    y_pos = 10'd512;
    step(3);
    y_pos = 10'd1000;
    step(10);
    checks++; if (tok_cnt !== t0 + 1) begin failures++; $display("FAIL short_release tokens=%0d exp=%0d", tok_cnt, t0 + 1); end
    y_pos = 10'd512;
    step(4);
    y_pos = 10'd1000;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL up2_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd3) begin failures++; $display("FAIL up2_token valid=%0b code=%0d exp=1/3", gest_valid, gest_code); end
    step(1);
    y_pos = 10'd512;
    step(6);
  endtask

  task automatic test_button;
    t0 = tok_cnt;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      step(2);
    end
    step(8);
    checks++; if (tok_cnt !== t0 || gest_valid !== 1'b0) begin failures++; $display("FAIL btn_bounce tokens=%0d valid=%0b exp=%0d/0", tok_cnt, gest_valid, t0); end
    btn = 1'b1;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL btn_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd5) begin failures++; $display("FAIL btn_token valid=%0b code=%0d exp=1/5", gest_valid, gest_code); end
    step(10);
    checks++; if (tok_cnt !== t0 + 1) begin failures++; $display("FAIL btn_once tokens=%0d exp=%0d", tok_cnt, t0 + 1); end
    btn = 1'b0;
    step(15);
    checks++; if (tok_cnt !== t0 + 1) begin failures++; $display("FAIL btn_release tokens=%0d exp=%0d", tok_cnt, t0 + 1); end
  endtask

  task automatic test_drop;
    gest_ready = 1'b0;
    x_pos = 10'd900;
    step(6);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd2) begin failures++; $display("FAIL stall_token valid=%0b code=%0d exp=1/2", gest_valid, gest_code); end
    y_pos = 10'd50;
    step(5);
    checks++; if (gest_drop !== 1'b0) begin failures++; $display("FAIL drop_early got=%0b exp=0", gest_drop); end
    step(1);
    checks++; if (gest_drop !== 1'b1 || gest_valid !== 1'b1 || gest_code !== 3'd2) begin failures++; $display("FAIL drop_pulse drop=%0b valid=%0b code=%0d exp=1/1/2", gest_drop, gest_valid, gest_code); end
    step(1);
    checks++; if (gest_drop !== 1'b0 || gest_code !== 3'd2) begin failures++; $display("FAIL drop_one_cycle drop=%0b code=%0d exp=0/2", gest_drop, gest_code); end
    gest_ready = 1'b1;
    step(1);
    checks++; if (gest_valid !== 1'b0 || gest_code !== 3'd0) begin failures++; $display("FAIL drain valid=%0b code=%0d exp=0/0", gest_valid, gest_code); end
    x_pos = 10'd512; y_pos = 10'd512;
    step(6);
  endtask

  task automatic test_simultaneous_reset;
    btn = 1'b1; y_pos = 10'd50;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL simul_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd5 || gest_drop !== 1'b1) begin failures++; $display("FAIL simul_prio valid=%0b code=%0d drop=%0b exp=1/5/1", gest_valid, gest_code, gest_drop); end
    step(1);
    checks++; if (gest_valid !== 1'b0 || gest_drop !== 1'b0) begin failures++; $display("FAIL simul_after valid=%0b drop=%0b exp=0/0", gest_valid, gest_drop); end
    btn = 1'b0; y_pos = 10'd512; x_pos = 10'd900;
    step(2);
    reset = 1'b1;
    step(1);
    checks++; if (gest_valid !== 1'b0 || gest_drop !== 1'b0 || stick_neutral !== 1'b0) begin failures++; $display("FAIL midreset valid=%0b drop=%0b neutral=%0b exp=0/0/0", gest_valid, gest_drop, stick_neutral); end
    reset = 1'b0;
    t0 = tok_cnt;
    step(20);
    checks++; if (tok_cnt !== t0 || gest_valid !== 1'b0) begin failures++; $display("FAIL qual_reset tokens=%0d valid=%0b exp=%0d/0", tok_cnt, gest_valid, t0); end
    x_pos = 10'd512;
    step(6);
    x_pos = 10'd900;
    step(5);
    checks++; if (gest_valid !== 1'b0) begin failures++; $display("FAIL rearm_early got=%0b exp=0", gest_valid); end
    step(1);
    checks++; if (gest_valid !== 1'b1 || gest_code !== 3'd2) begin failures++; $display("FAIL rearm_token valid=%0b code=%0d exp=1/2", gest_valid, gest_code); end
    step(1);
  endtask

  initial begin
    test_reset();
    test_right();
    test_hold_left();
    test_short_up();
    test_button();
    test_drop();
    test_simultaneous_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
